// File: rtl/string_matcher.sv
// Shift-and (bitap) match engine with a match-event FIFO and AXI-Stream output.
// Optional match counter is built when STRING_MATCHER_MATCH_COUNT_EN is defined.
module string_matcher #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POS_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_axis_tvalid,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tuser,
  input  logic [2:0]           pattern_last,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [POS_WIDTH-1:0] m_axis_tdata,
  output logic                 overflow,
  output logic [15:0]          match_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  // Match state and string position
  logic [7:0]           d_q, d_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 hit;

  // Pending event register between detection and FIFO write
  logic                 pend_q, pend_d;
  logic [POS_WIDTH-1:0] pend_pos_q, pend_pos_d;

  // FIFO state
  logic [POS_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 full, push, pop, drop;

  always_comb begin
    d_d   = d_q;
    pos_d = pos_q;
    hit   = 1'b0;
    if (s_axis_tvalid) begin
      if (s_axis_tuser) begin
        d_d   = s_axis_tdata & 8'h01;
        pos_d = '0;
      end else begin
        d_d   = ((d_q << 1) | 8'h01) & s_axis_tdata;
        pos_d = pos_q + POS_WIDTH'(1);
      end
      hit = d_d[pattern_last];
    end
    pend_d     = hit;
    pend_pos_d = hit ? pos_d : pend_pos_q;
  end

  always_comb begin
    full       = (cnt_q == CntFull);
    pop        = (cnt_q != '0) && m_axis_tready;
    // A simultaneous pop frees the slot the pending write needs.
    push       = pend_q && (!full || pop);
    drop       = pend_q && full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d      = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      d_q        <= '0;
      pos_q      <= '0;
      pend_q     <= 1'b0;
      pend_pos_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      d_q        <= d_d;
      pos_q      <= pos_d;
      pend_q     <= pend_d;
      pend_pos_q <= pend_pos_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= pend_pos_q;
    end
  end

  assign m_axis_tvalid = (cnt_q != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  assign overflow      = overflow_q;

`ifdef STRING_MATCHER_MATCH_COUNT_EN
  logic [15:0] match_cnt_q, match_cnt_d;

  // Counts detections, so events later dropped on overflow are included.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (hit && (match_cnt_q != 16'hFFFF)) begin
      match_cnt_d = match_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      match_cnt_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
    end
  end

  assign match_count = match_cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_string_matcher.sv
// Scoreboard bench for string_matcher: a bitap model pushes expected positions,
// the output monitor pops and compares on every accepted event.
module tb_string_matcher;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tuser = 1'b0;
  logic [2:0]  pattern_last = 3'd1;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        overflow;
  logic [15:0] match_count;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [15:0] exp_q [$];
  logic [7:0]  mdl_d;
  logic [15:0] mdl_pos;
  bit          auto_push;

  string_matcher #(
    .FIFO_DEPTH(4),
    .POS_WIDTH (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tuser (s_axis_tuser),
    .pattern_last (pattern_last),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .overflow     (overflow),
    .match_count  (match_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor; sampled on the falling edge, the pop happens at the next rising edge.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("spurious_event", 32'(exp_q.size()), 32'd1);
      end else begin
        check("event_pos", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    mdl_d   = '0;
    mdl_pos = '0;
    exp_q.delete();
  endtask

  task automatic send_beat(input logic tuser, input logic [7:0] data, input int gap);
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = tuser;
    s_axis_tdata  = data;
    if (tuser) begin
      mdl_d   = data & 8'h01;
      mdl_pos = '0;
    end else begin
      mdl_d   = ((mdl_d << 1) | 8'h01) & data;
      mdl_pos = mdl_pos + 16'd1;
    end
    if (mdl_d[pattern_last] && auto_push) exp_q.push_back(mdl_pos);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tdata  = '0;
    repeat (gap) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_ab(input int gap);
    send_beat(1'b1, 8'h00, gap);
    send_beat(1'b0, 8'h01, gap);
    send_beat(1'b0, 8'h02, gap);
    send_beat(1'b0, 8'h01, gap);
    send_beat(1'b0, 8'h02, gap);
  endtask

  task automatic wait_drain(input string tag);
    int budget = 60;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge aclk);
      #1;
      budget--;
    end
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_cnt;
    auto_push = 1'b1;
    mdl_d     = '0;
    mdl_pos   = '0;
    do_reset();
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_match_count", 32'(match_count), 32'd0);

    // Pattern "ab": events at 2 and 4
    pattern_last  = 3'd1;
    m_axis_tready = 1'b1;
    send_ab(0);
    wait_drain("ab_drain");
    check("ab_overflow", 32'(overflow), 32'd0);

    // Restart mid-stream: events at 2 then 1
    send_beat(1'b1, 8'h00, 0);
    send_beat(1'b0, 8'h01, 0);
    send_beat(1'b0, 8'h02, 0);
    send_beat(1'b0, 8'h01, 0);
    send_beat(1'b1, 8'h01, 0);
    send_beat(1'b0, 8'h02, 0);
    wait_drain("restart_drain");

    // Overflow: six single-char matches into a 4-deep FIFO
    do_reset();
    pattern_last  = 3'd0;
    m_axis_tready = 1'b0;
    auto_push     = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(i == 0, 8'h01, 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    check("ovf_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("ovf_head_stable", 32'(m_axis_tdata), 32'd0);
    check("ovf_flag", 32'(overflow), 32'd1);
`ifdef STRING_MATCHER_MATCH_COUNT_EN
    exp_cnt = 16'd6;
`else
    exp_cnt = 16'd0;
`endif
    check("ovf_match_count", 32'(match_count), 32'(exp_cnt));
    m_axis_tready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'd1);
    auto_push = 1'b1;

    // Full FIFO with a pop on the same edge as the pending write
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(i == 0, 8'h01, 0);
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b0;
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    check("pulse_overflow", 32'(overflow), 32'd0);
    check("pulse_tvalid", 32'(m_axis_tvalid), 32'd1);
    m_axis_tready = 1'b1;
    wait_drain("pulse_drain");
    check("pulse_overflow_end", 32'(overflow), 32'd0);

    // Reset mid-string with two events queued; model state ends at D=1
    pattern_last  = 3'd1;
    m_axis_tready = 1'b0;
    send_ab(0);
    send_beat(1'b0, 8'h01, 0);
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    do_reset();
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    m_axis_tready = 1'b1;
    // Would match at pos 1 only if D survived the reset
    send_beat(1'b0, 8'h02, 0);
    repeat (4) begin
      @(posedge aclk);
      #1;
    end
    check("mid_rst_d_clear", 32'(m_axis_tvalid), 32'd0);
    send_ab(0);
    wait_drain("post_rst_drain");

    // Same "ab" stream with valid every third cycle
    send_ab(2);
    wait_drain("gap_drain");
    check("gap_overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
